// File: rtl/mprj_io_ctrl_if.sv
// Configuration register bus between a host and the mprj_io_ctrl pad controller.
// The host owns the strobes, address and write data; the controller returns registered read data.
interface mprj_io_ctrl_if #(
  parameter int ADDR_W = 7
) ();
  logic              cfg_we;
  logic              cfg_re;
  logic [ADDR_W-1:0] cfg_addr;
  logic [15:0]       cfg_wdata;
  logic [15:0]       cfg_rdata;

  modport master (
    output cfg_we, cfg_re, cfg_addr, cfg_wdata,
    input  cfg_rdata
  );

  modport slave (
    input  cfg_we, cfg_re, cfg_addr, cfg_wdata,
    output cfg_rdata
  );
endinterface

// File: rtl/mprj_io_ctrl.sv
// Per-pad configuration, output registering, and input synchronise/debounce/edge capture
// for the mprj_io pad array, with W1C pending bits ORed into a single interrupt.
module mprj_io_ctrl #(
  parameter int NUM_PADS    = 38,
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 7
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  mprj_io_ctrl_if.slave         cfg,
  input  logic [NUM_PADS-1:0]   core_out,
  output logic [NUM_PADS-1:0]   core_in,
  output logic                  irq,
  output logic [NUM_PADS-1:0]   io_out,
  output logic [NUM_PADS-1:0]   oeb,
  output logic [NUM_PADS-1:0]   inp_dis,
  output logic [3*NUM_PADS-1:0] dm,
  input  logic [NUM_PADS-1:0]   io_in
);

  localparam int          NUM_WORDS = (NUM_PADS + 15) / 16;
  localparam logic [15:0] CFG_RESET = 16'h0009;

  logic [ADDR_W-1:0]       addr;
  logic [31:0]             addr_ext;
  logic [15:0]             cfg_words [NUM_PADS];
  logic [NUM_PADS-1:0]     filt;
  logic [NUM_PADS-1:0]     pending;
  logic [16*NUM_WORDS-1:0] pending_ext;
  logic [15:0]             rdata_next;

  assign addr     = cfg.cfg_addr;
  assign addr_ext = 32'(addr);

  for (genvar n = 0; n < NUM_PADS; n++) begin : g_pad
    localparam logic [31:0] CFG_ADDR = 32'(n);
    localparam logic [31:0] STS_ADDR = 32'(NUM_PADS + n / 16);
    localparam int          STS_BIT  = n % 16;

    logic [15:0]            cfg_r;
    logic [SYNC_STAGES-1:0] sync_r;
    logic [7:0]             cnt_r;
    logic                   f_r;
    logic                   f_prev_r;
    logic                   pend_r;
    logic                   out_r;
    logic                   cfg_sel;
    logic                   pend_clr;
    logic                   pend_set;
    logic                   s;

    assign cfg_sel  = cfg.cfg_we && (addr_ext == CFG_ADDR);
    assign pend_clr = cfg.cfg_we && (addr_ext == STS_ADDR) && cfg.cfg_wdata[STS_BIT];
    assign s        = sync_r[SYNC_STAGES-1];
    assign pend_set = (cfg_r[6] & f_r & ~f_prev_r) | (cfg_r[7] & ~f_r & f_prev_r);

    // A config rewrite restarts the debounce window but leaves f and pending alone;
    // a new edge beats a same-cycle W1C clear.
    always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
        cfg_r    <= CFG_RESET;
        sync_r   <= '0;
        cnt_r    <= '0;
        f_r      <= 1'b0;
        f_prev_r <= 1'b0;
        pend_r   <= 1'b0;
        out_r    <= 1'b0;
      end else begin
        if (cfg_sel) cfg_r <= cfg.cfg_wdata;
        sync_r   <= {sync_r[SYNC_STAGES-2:0], io_in[n] & ~cfg_r[4]};
        f_prev_r <= f_r;
        out_r    <= core_out[n];
        pend_r   <= pend_set | (pend_r & ~pend_clr);

        if (!cfg_r[5]) begin
          f_r   <= s;
          cnt_r <= '0;
        end else if (s == f_r) begin
          cnt_r <= '0;
        end else if (cnt_r == cfg_r[15:8]) begin
          f_r   <= s;
          cnt_r <= '0;
        end else begin
          cnt_r <= cnt_r + 8'd1;
        end

        if (cfg_sel) cnt_r <= '0;
      end
    end

    assign cfg_words[n]  = cfg_r;
    assign dm[3*n +: 3]  = cfg_r[2:0];
    assign oeb[n]        = cfg_r[3];
    assign inp_dis[n]    = cfg_r[4];
    assign io_out[n]     = out_r;
    assign filt[n]       = f_r;
    assign pending[n]    = pend_r;
  end

  always_comb begin
    pending_ext                 = '0;
    pending_ext[NUM_PADS-1:0]   = pending;
  end

  // Unmapped addresses fall through to zero.
  always_comb begin
    rdata_next = '0;
    for (int n = 0; n < NUM_PADS; n++) begin
      if (addr_ext == 32'(n)) rdata_next = cfg_words[n];
    end
    for (int k = 0; k < NUM_WORDS; k++) begin
      if (addr_ext == 32'(NUM_PADS + k)) rdata_next = pending_ext[16*k +: 16];
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cfg.cfg_rdata <= '0;
    end else if (cfg.cfg_re) begin
      cfg.cfg_rdata <= rdata_next;
    end
  end

  assign irq     = |pending;
  assign core_in = filt;

endmodule

// File: tb/tb_mprj_io_ctrl.sv
// Directed bench for mprj_io_ctrl: a register/pad-output vector table followed by
// hand-written sequences for debounce, edge capture, W1C races and reset corner cases.
module tb_mprj_io_ctrl;
  localparam int NUM_PADS    = 38;
  localparam int SYNC_STAGES = 2;
  localparam int ADDR_W      = 7;

  logic                  wb_clk_i = 1'b0;
  logic                  wb_rst_i;
  logic [NUM_PADS-1:0]   core_out;
  logic [NUM_PADS-1:0]   core_in;
  logic                  irq;
  logic [NUM_PADS-1:0]   io_out;
  logic [NUM_PADS-1:0]   oeb;
  logic [NUM_PADS-1:0]   inp_dis;
  logic [3*NUM_PADS-1:0] dm;
  logic [NUM_PADS-1:0]   io_in;

  int errors = 0;
  int checks = 0;

  mprj_io_ctrl_if #(.ADDR_W(ADDR_W)) cfg_bus ();

  mprj_io_ctrl #(
    .NUM_PADS    (NUM_PADS),
    .SYNC_STAGES (SYNC_STAGES),
    .ADDR_W      (ADDR_W)
  ) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .cfg      (cfg_bus),
    .core_out (core_out),
    .core_in  (core_in),
    .irq      (irq),
    .io_out   (io_out),
    .oeb      (oeb),
    .inp_dis  (inp_dis),
    .dm       (dm),
    .io_in    (io_in)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct {
    logic [6:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    int          pad;
    logic [2:0]  exp_dm;
    logic        exp_oeb;
    logic        exp_dis;
  } vec_t;

  vec_t vecs [7];

  task automatic step();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic re, input logic [6:0] addr,
                               input logic [15:0] wdata);
    cfg_bus.cfg_we    = we;
    cfg_bus.cfg_re    = re;
    cfg_bus.cfg_addr  = addr;
    cfg_bus.cfg_wdata = wdata;
    step();
    cfg_bus.cfg_we = 1'b0;
    cfg_bus.cfg_re = 1'b0;
  endtask

  task automatic read_reg(input logic [6:0] addr, output logic [15:0] data);
    applyStimulus(1'b0, 1'b1, addr, 16'h0000);
    data = cfg_bus.cfg_rdata;
  endtask

  task automatic wait_core_in(input int pad, input int max_cycles, output int lat);
    lat = -1;
    for (int i = 1; i <= max_cycles; i++) begin
      step();
      if (core_in[pad] === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic wait_irq(input int max_cycles, output int lat);
    lat = -1;
    for (int i = 1; i <= max_cycles; i++) begin
      step();
      if (irq === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    checkOutput({tag, "_oeb"},     oeb,     {NUM_PADS{1'b1}});
    checkOutput({tag, "_dm"},      dm,      {NUM_PADS{3'b001}});
    checkOutput({tag, "_inp_dis"}, inp_dis, '0);
    checkOutput({tag, "_io_out"},  io_out,  '0);
    checkOutput({tag, "_core_in"}, core_in, '0);
    checkOutput({tag, "_irq"},     irq,     1'b0);
  endtask

  initial begin
    logic [15:0] rd;
    int          lat;
    logic        bad;

    vecs[0] = '{7'd0,   16'hFFFF, 16'hFFFF, 0,  3'b111, 1'b1, 1'b1};
    vecs[1] = '{7'd37,  16'h1234, 16'h1234, 37, 3'b100, 1'b0, 1'b1};
    vecs[2] = '{7'd5,   16'h0006, 16'h0006, 5,  3'b110, 1'b0, 1'b0};
    vecs[3] = '{7'd40,  16'hFFFF, 16'h0000, 5,  3'b110, 1'b0, 1'b0};
    vecs[4] = '{7'd41,  16'h5555, 16'h0000, 0,  3'b111, 1'b1, 1'b1};
    vecs[5] = '{7'd127, 16'h0000, 16'h0000, 37, 3'b100, 1'b0, 1'b1};
    vecs[6] = '{7'd1,   16'h0010, 16'h0010, 1,  3'b000, 1'b0, 1'b1};

    wb_rst_i          = 1'b1;
    core_out          = '0;
    io_in             = '0;
    cfg_bus.cfg_we    = 1'b0;
    cfg_bus.cfg_re    = 1'b0;
    cfg_bus.cfg_addr  = '0;
    cfg_bus.cfg_wdata = '0;

    // Power-on reset
    step();
    step();
    wb_rst_i = 1'b0;
    check_reset_state("por");
    read_reg(7'd0, rd);
    checkOutput("por_cfg0", rd, 16'h0009);

    // Register/pad-output vector table
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, 1'b0, vecs[i].addr, vecs[i].wdata);
      checkOutput($sformatf("vec%0d_dm", i),  dm[3*vecs[i].pad +: 3], vecs[i].exp_dm);
      checkOutput($sformatf("vec%0d_oeb", i), oeb[vecs[i].pad],       vecs[i].exp_oeb);
      checkOutput($sformatf("vec%0d_dis", i), inp_dis[vecs[i].pad],   vecs[i].exp_dis);
      read_reg(vecs[i].addr, rd);
      checkOutput($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
    end

    wb_rst_i = 1'b1;
    step();
    step();
    wb_rst_i = 1'b0;

    // Output path on pad 5
    applyStimulus(1'b1, 1'b0, 7'd5, 16'h0006);
    checkOutput("out_oeb5", oeb[5], 1'b0);
    checkOutput("out_dm5", dm[17:15], 3'b110);
    core_out[5] = 1'b1;
    checkOutput("out_io5_before", io_out[5], 1'b0);
    step();
    checkOutput("out_io5_after", io_out[5], 1'b1);

    // Debounce on pad 3: short glitch rejected, steady level accepted
    applyStimulus(1'b1, 1'b0, 7'd3, 16'h0420);
    bad = 1'b0;
    io_in[3] = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (i == 3) io_in[3] = 1'b0;
      step();
      if (core_in[3] !== 1'b0) bad = 1'b1;
    end
    checkOutput("db_glitch", bad, 1'b0);
    io_in[3] = 1'b1;
    wait_core_in(3, 30, lat);
    checkOutput("db_latency", 32'(lat), 32'(SYNC_STAGES + 5));

    // Edge capture and W1C on pad 20
    applyStimulus(1'b1, 1'b0, 7'd20, 16'h00C9);
    io_in[20] = 1'b1;
    wait_irq(20, lat);
    checkOutput("edge_irq_latency", 32'(lat), 32'(SYNC_STAGES + 2));
    read_reg(7'd39, rd);
    checkOutput("edge_status", rd, 16'h0010);
    applyStimulus(1'b1, 1'b0, 7'd39, 16'h0010);
    checkOutput("w1c_irq", irq, 1'b0);
    read_reg(7'd39, rd);
    checkOutput("w1c_status", rd, 16'h0000);
    io_in[20] = 1'b0;
    step();
    step();
    step();
    applyStimulus(1'b1, 1'b0, 7'd39, 16'h0010);
    checkOutput("race_irq", irq, 1'b1);
    read_reg(7'd39, rd);
    checkOutput("race_status", rd, 16'h0010);
    applyStimulus(1'b1, 1'b0, 7'd39, 16'h0010);
    checkOutput("race_cleared", irq, 1'b0);

    // Mid-count config rewrite on pad 7
    applyStimulus(1'b1, 1'b0, 7'd7, 16'h0A20);
    io_in[7] = 1'b1;
    for (int i = 0; i < 6; i++) step();
    applyStimulus(1'b1, 1'b0, 7'd7, 16'h0A20);
    checkOutput("midcnt_low", core_in[7], 1'b0);
    wait_core_in(7, 30, lat);
    checkOutput("midcnt_latency", 32'(lat), 32'd11);

    // Reset while pad 3 has pending set and its counter at 2
    applyStimulus(1'b1, 1'b0, 7'd3, 16'h04E0);
    io_in[3] = 1'b0;
    wait_irq(30, lat);
    checkOutput("pad3_fall_irq_latency", 32'(lat), 32'(SYNC_STAGES + 6));
    io_in[3] = 1'b1;
    for (int i = 0; i < 4; i++) step();
    checkOutput("pre_reset_irq", irq, 1'b1);
    wb_rst_i = 1'b1;
    step();
    check_reset_state("midrst");
    wb_rst_i = 1'b0;
    read_reg(7'd3, rd);
    checkOutput("midrst_cfg3", rd, 16'h0009);

    // Same-cycle read and write returns the old value; read data holds
    applyStimulus(1'b1, 1'b1, 7'd10, 16'hABCD);
    checkOutput("rw_same_cycle", cfg_bus.cfg_rdata, 16'h0009);
    checkOutput("rw_dm10", dm[32:30], 3'b101);
    step();
    step();
    step();
    checkOutput("rdata_hold", cfg_bus.cfg_rdata, 16'h0009);
    read_reg(7'd10, rd);
    checkOutput("rw_new_value", rd, 16'hABCD);

    // A write coincident with reset is dropped
    wb_rst_i = 1'b1;
    applyStimulus(1'b1, 1'b0, 7'd11, 16'h5555);
    wb_rst_i = 1'b0;
    read_reg(7'd11, rd);
    checkOutput("we_during_reset", rd, 16'h0009);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
